// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Bout, Ovf
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Bout, Ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: Diff = A - B - Bin with borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell reused for WIDTH cycles.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 bits already produced; the final bit joins on the last step.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_nx_c;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d_c;
  logic             bnext_c;
  logic             last_c;

  full_subtractor u_fs (
    .A   (a_sr[0]),
    .B   (b_sr[0]),
    .Bin (borrow),
    .Diff(d_c),
    .Bout(bnext_c)
  );

  assign last_c   = (cnt == CW'(WIDTH - 1));
  assign res_nx_c = {d_c, res_sr};

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last_c)    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath, handshake flags and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Diff <= '0;
      bus.Bout <= 1'b0;
      bus.Ovf  <= 1'b0;
    end else begin
      bus.busy <= (state_nx == RUN);
      bus.done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nx_c[WIDTH-1:1];
          borrow <= bnext_c;
          if (last_c) begin
            bus.Diff <= res_nx_c;
            bus.Bout <= bnext_c;
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            bus.Ovf  <= borrow ^ bnext_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic        busy;
    logic        done;
    logic        bout;
    logic        ovf;
    logic [15:0] diff;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8();
  serial_subtractor_if #(.WIDTH(16)) bus16();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a_in, input logic [15:0] b_in);
    exp_t        r;
    logic [15:0] mask;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] full;
    logic        sa, sgb, sd;
    mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
    a      = a_in & mask;
    b      = b_in & mask;
    full   = {1'b0, a} - {1'b0, b};
    r.diff = full[15:0] & mask;
    r.bout = (a < b);
    sa     = (w == 16) ? a[15] : a[7];
    sgb    = (w == 16) ? b[15] : b[7];
    sd     = (w == 16) ? r.diff[15] : r.diff[7];
    r.ovf  = (sa != sgb) && (sd != sa);
    return r;
  endfunction

  function automatic obs_t obs(input int w);
    obs_t o;
    if (w == 16) begin
      o.busy = bus16.busy; o.done = bus16.done; o.bout = bus16.Bout;
      o.ovf  = bus16.Ovf;  o.diff = bus16.Diff;
    end else begin
      o.busy = bus8.busy; o.done = bus8.done; o.bout = bus8.Bout;
      o.ovf  = bus8.Ovf;  o.diff = 16'(bus8.Diff);
    end
    return o;
  endfunction

  task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
    if (w == 16) begin
      bus16.start = s; bus16.A = a; bus16.B = b;
    end else begin
      bus8.start = s; bus8.A = a[7:0]; bus8.B = b[7:0];
    end
  endtask

  // Called #1 after the accepting edge: checks busy, latency, result and done width.
  task automatic collect(input int w);
    obs_t o;
    exp_t e;
    int   n;
    bit   busy_ok;
    o = obs(w);
    check("busy_after_accept", 32'(o.busy), 32'd1);
    busy_ok = 1'b1;
    n = 0;
    for (int i = 1; i <= w + 4; i++) begin
      @(posedge clk); #1;
      o = obs(w);
      if (o.done) begin
        n = i;
        break;
      end
      if (!o.busy) busy_ok = 1'b0;
    end
    check("busy_held", 32'(busy_ok), 32'd1);
    check("done_latency", 32'(n), 32'(w));
    if (sb.size() > 0) e = sb.pop_front();
    if (n != 0) begin
      check("diff", 32'(o.diff), 32'(e.diff));
      check("bout", 32'(o.bout), 32'(e.bout));
      check("ovf", 32'(o.ovf), 32'(e.ovf));
      check("busy_in_done", 32'(o.busy), 32'd0);
      @(posedge clk); #1;
      o = obs(w);
      check("done_one_cycle", 32'(o.done), 32'd0);
    end
  endtask

  task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input exp_t e);
    @(negedge clk);
    drive(w, 1'b1, a, b);
    sb.push_back(e);
    @(posedge clk); #1;
    drive(w, 1'b0, 16'h0, 16'h0);
    collect(w);
  endtask

  initial begin
    vec_t       vt[9];
    exp_t       e;
    obs_t       o;
    logic [7:0] ra, rb;
    bit         quiet;

    vt[0] = '{8'd100, 8'd37,  8'd63,  1'b0, 1'b0};
    vt[1] = '{8'h05,  8'h09,  8'hFC,  1'b1, 1'b0};
    vt[2] = '{8'h00,  8'h00,  8'h00,  1'b0, 1'b0};
    vt[3] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
    vt[4] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
    vt[5] = '{8'h00,  8'h01,  8'hFF,  1'b1, 1'b0};
    vt[6] = '{8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0};
    vt[7] = '{8'h80,  8'h7F,  8'h01,  1'b0, 1'b1};
    vt[8] = '{8'h01,  8'h80,  8'h81,  1'b1, 1'b1};

    drive(8, 1'b0, 16'h0, 16'h0);
    drive(16, 1'b0, 16'h0, 16'h0);

    // Reset state of both instances.
    #2;
    o = obs(8);
    check("reset8", 32'({o.busy, o.done, o.bout, o.ovf, o.diff}), 32'd0);
    o = obs(16);
    check("reset16", 32'({o.busy, o.done, o.bout, o.ovf, o.diff}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      e.diff = 16'(vt[i].diff);
      e.bout = vt[i].bout;
      e.ovf  = vt[i].ovf;
      op(8, 16'(vt[i].a), 16'(vt[i].b), e);
    end

    // start held high with operands changing during RUN and DONE.
    @(negedge clk);
    drive(8, 1'b1, 16'd10, 16'd3);
    e.diff = 16'd7; e.bout = 1'b0; e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    quiet = 1'b1;
    ra = 8'h0; rb = 8'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      drive(8, 1'b1, 16'(ra), 16'(rb));
      @(posedge clk); #1;
      o = obs(8);
      if (i < 8) begin
        if (!o.busy || o.done) quiet = 1'b0;
      end else if (i == 8) begin
        check("ign_done", 32'(o.done), 32'd1);
        e = sb.pop_front();
        check("ign_diff", 32'(o.diff), 32'(e.diff));
        check("ign_bout_ovf", 32'({o.bout, o.ovf}), 32'({e.bout, e.ovf}));
      end else if (i == 9) begin
        check("ign_done_state", 32'({o.busy, o.done}), 32'd0);
      end
    end
    check("ign_run_steady", 32'(quiet), 32'd1);
    sb.push_back(model(8, 16'(ra), 16'(rb)));
    drive(8, 1'b0, 16'h0, 16'h0);
    collect(8);

    // Reset asserted during bit-step 4 abandons the operation.
    op(8, 16'h01, 16'h80, model(8, 16'h01, 16'h80));
    @(negedge clk);
    drive(8, 1'b1, 16'd50, 16'd20);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'h0, 16'h0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    o = obs(8);
    check("midrun_reset_outputs", 32'({o.busy, o.done, o.bout, o.ovf, o.diff}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      o = obs(8);
      if (o.done || o.busy) quiet = 1'b0;
    end
    check("no_done_after_reset", 32'(quiet), 32'd1);
    e.diff = 16'd30; e.bout = 1'b0; e.ovf = 1'b0;
    op(8, 16'd50, 16'd20, e);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      op(8, a & 16'h00FF, b & 16'h00FF, model(8, a, b));
      a = 16'($urandom);
      b = 16'($urandom);
      op(16, a, b, model(16, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
